// File: rtl/writeback_regfile.sv
// Write-back stage and 31-entry register file (x0 hard-wired to zero) with a committed-write counter.
// Define WRITEBACK_BYPASS_EN to forward the in-flight write-back value to matching read ports.
module writeback_regfile #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             RegWrite_i,
  input  logic             MemtoReg_i,
  input  logic [31:0]      MemData_i,
  input  logic [31:0]      RegData_i,
  input  logic [4:0]       RegAddr_i,
  input  logic [4:0]       RSaddr_i,
  input  logic [4:0]       RTaddr_i,
  output logic [31:0]      RSdata_o,
  output logic [31:0]      RTdata_o,
  output logic [31:0]      WBdata_o,
  output logic [CNT_W-1:0] WrCount_o
);

  logic [31:0]      regs [1:31];
  logic [CNT_W-1:0] wr_count;
  logic             commit;

  assign WBdata_o  = MemtoReg_i ? MemData_i : RegData_i;
  assign commit    = RegWrite_i && (RegAddr_i != 5'd0);
  assign WrCount_o = wr_count;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 1; i < 32; i++) begin
        regs[i] <= 32'd0;
      end
      wr_count <= '0;
    end else if (commit) begin
      regs[RegAddr_i] <= WBdata_o;
      wr_count        <= wr_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Reads are gated by reset so the ports are zero for the whole reset window.
  always_comb begin
    RSdata_o = 32'd0;
    if (rst_i && (RSaddr_i != 5'd0)) begin
`ifdef WRITEBACK_BYPASS_EN
      if (commit && (RSaddr_i == RegAddr_i)) begin
        RSdata_o = WBdata_o;
      end else begin
        RSdata_o = regs[RSaddr_i];
      end
`else
      RSdata_o = regs[RSaddr_i];
`endif
    end
  end

  always_comb begin
    RTdata_o = 32'd0;
    if (rst_i && (RTaddr_i != 5'd0)) begin
`ifdef WRITEBACK_BYPASS_EN
      if (commit && (RTaddr_i == RegAddr_i)) begin
        RTdata_o = WBdata_o;
      end else begin
        RTdata_o = regs[RTaddr_i];
      end
`else
      RTdata_o = regs[RTaddr_i];
`endif
    end
  end

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile; counter runs at 4 bits so wrap-around is reachable.
module tb_writeback_regfile;
  localparam int CNT_W = 4;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             RegWrite_i;
  logic             MemtoReg_i;
  logic [31:0]      MemData_i;
  logic [31:0]      RegData_i;
  logic [4:0]       RegAddr_i;
  logic [4:0]       RSaddr_i;
  logic [4:0]       RTaddr_i;
  logic [31:0]      RSdata_o;
  logic [31:0]      RTdata_o;
  logic [31:0]      WBdata_o;
  logic [CNT_W-1:0] WrCount_o;

  int               n_checks = 0;
  int               n_fail   = 0;
  logic [CNT_W-1:0] exp_cnt  = '0;

  writeback_regfile #(.CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i),
    .MemData_i(MemData_i), .RegData_i(RegData_i), .RegAddr_i(RegAddr_i),
    .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i), .RSdata_o(RSdata_o), .RTdata_o(RTdata_o),
    .WBdata_o(WBdata_o), .WrCount_o(WrCount_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic apply_reset();
    rst_i = 1'b0; RegWrite_i = 1'b0; MemtoReg_i = 1'b0; MemData_i = '0; RegData_i = '0;
    RegAddr_i = '0; RSaddr_i = '0; RTaddr_i = '0;
    exp_cnt = '0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  // One write committing at the next rising edge; the expected counter follows it.
  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic mem);
    @(negedge clk_i);
    RegWrite_i = 1'b1; RegAddr_i = a; MemtoReg_i = mem;
    if (mem) MemData_i = d; else RegData_i = d;
    @(posedge clk_i);
    if (a != 5'd0) exp_cnt = exp_cnt + 1'b1;
    #1;
    RegWrite_i = 1'b0;
  endtask

  task automatic set_read(input logic [4:0] a, input logic [4:0] b);
    RSaddr_i = a; RTaddr_i = b; #1;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int i = 0; i < 32; i += 7) begin
      set_read(5'(i), 5'(31 - i));
      n_checks++;
      if (RSdata_o !== 32'd0 || RTdata_o !== 32'd0) begin
        n_fail++; $display("FAIL reset_read idx=%0d rs=%h rt=%h required 0", i, RSdata_o, RTdata_o);
      end
    end
    n_checks++;
    if (WrCount_o !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d required 0", WrCount_o); end
  endtask

  task automatic test_source_select();
    @(negedge clk_i);
    RegWrite_i = 1'b1; RegAddr_i = 5'd7; MemtoReg_i = 1'b1;
    MemData_i = 32'h12345678; RegData_i = 32'hFFFFFFFF; #1;
    n_checks++;
    if (WBdata_o !== 32'h12345678) begin n_fail++; $display("FAIL wb_mem got %h required 12345678", WBdata_o); end
    MemtoReg_i = 1'b0; #1;
    n_checks++;
    if (WBdata_o !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL wb_alu got %h required ffffffff", WBdata_o); end
    RegWrite_i = 1'b0; MemtoReg_i = 1'b0; #1;
    n_checks++;
    if (WBdata_o !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL wb_no_write got %h required ffffffff", WBdata_o); end
    do_write(5'd7, 32'h12345678, 1'b1);
    set_read(5'd7, 5'd0);
    n_checks++;
    if (RSdata_o !== 32'h12345678 || RTdata_o !== 32'd0) begin
      n_fail++; $display("FAIL x7_mem rs=%h rt=%h required 12345678/0", RSdata_o, RTdata_o);
    end
    n_checks++;
    if (WrCount_o !== 4'd1) begin n_fail++; $display("FAIL count_after_x7 got %0d required 1", WrCount_o); end
    do_write(5'd8, 32'h8000_0001, 1'b0);
    set_read(5'd0, 5'd8);
    n_checks++;
    if (RTdata_o !== 32'h8000_0001) begin n_fail++; $display("FAIL x8_alu got %h required 80000001", RTdata_o); end
  endtask

  task automatic test_x0_write();
    do_write(5'd0, 32'hAAAA5555, 1'b0);
    set_read(5'd0, 5'd0);
    n_checks++;
    if (RSdata_o !== 32'd0 || RTdata_o !== 32'd0) begin
      n_fail++; $display("FAIL x0_read rs=%h rt=%h required 0", RSdata_o, RTdata_o);
    end
    n_checks++;
    if (WrCount_o !== 4'd2) begin n_fail++; $display("FAIL x0_count got %0d required 2", WrCount_o); end
  endtask

  task automatic test_bypass();
    logic [31:0] exp_pre;
`ifdef WRITEBACK_BYPASS_EN
    exp_pre = 32'h55;
`else
    exp_pre = 32'h1;
`endif
    do_write(5'd9, 32'h1, 1'b0);
    @(negedge clk_i);
    RegWrite_i = 1'b1; RegAddr_i = 5'd9; MemtoReg_i = 1'b0; RegData_i = 32'h55;
    set_read(5'd9, 5'd9);
    n_checks++;
    if (RSdata_o !== exp_pre || RTdata_o !== exp_pre) begin
      n_fail++; $display("FAIL bypass_pre rs=%h rt=%h required %h", RSdata_o, RTdata_o, exp_pre);
    end
    @(posedge clk_i);
    exp_cnt = exp_cnt + 1'b1;
    #1; RegWrite_i = 1'b0; #1;
    n_checks++;
    if (RSdata_o !== 32'h55 || RTdata_o !== 32'h55) begin
      n_fail++; $display("FAIL bypass_post rs=%h rt=%h required 55", RSdata_o, RTdata_o);
    end
    n_checks++;
    if (WrCount_o !== exp_cnt) begin n_fail++; $display("FAIL bypass_count got %0d required %0d", WrCount_o, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    do_write(5'd3, 32'd1, 1'b0);
    do_write(5'd3, 32'd2, 1'b1);
    do_write(5'd3, 32'd3, 1'b0);
    set_read(5'd3, 5'd3);
    n_checks++;
    if (RSdata_o !== 32'd3 || RTdata_o !== 32'd3) begin
      n_fail++; $display("FAIL burst_x3 rs=%h rt=%h required 3", RSdata_o, RTdata_o);
    end
    n_checks++;
    if (WrCount_o !== 4'd3) begin n_fail++; $display("FAIL burst_count got %0d required 3", WrCount_o); end
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int i = 1; i <= 15; i++) do_write(5'(i), 32'(i) * 32'h0101_0101, 1'b0);
    n_checks++;
    if (WrCount_o !== 4'd15) begin n_fail++; $display("FAIL count_15 got %0d required 15", WrCount_o); end
    do_write(5'd31, 32'hFFFF_0000, 1'b0);
    n_checks++;
    if (WrCount_o !== 4'd0) begin n_fail++; $display("FAIL count_wrap got %0d required 0", WrCount_o); end
    set_read(5'd15, 5'd31);
    n_checks++;
    if (RSdata_o !== 32'h0F0F_0F0F || RTdata_o !== 32'hFFFF_0000) begin
      n_fail++; $display("FAIL wrap_data rs=%h rt=%h required 0f0f0f0f/ffff0000", RSdata_o, RTdata_o);
    end
  endtask

  task automatic test_mid_reset();
    do_write(5'd5, 32'hDEADBEEF, 1'b0);
    set_read(5'd5, 5'd5);
    n_checks++;
    if (RSdata_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL x5_before_reset got %h required deadbeef", RSdata_o); end
    #2 rst_i = 1'b0; #1;
    n_checks++;
    if (RSdata_o !== 32'd0 || WrCount_o !== 4'd0) begin
      n_fail++; $display("FAIL async_reset rs=%h cnt=%0d required 0/0", RSdata_o, WrCount_o);
    end
    exp_cnt = '0;
    @(negedge clk_i); rst_i = 1'b1; #1;
    n_checks++;
    if (RSdata_o !== 32'd0) begin n_fail++; $display("FAIL x5_after_reset got %h required 0", RSdata_o); end
  endtask

  task automatic test_reset_discard();
    logic [31:0] exp_pre;
`ifdef WRITEBACK_BYPASS_EN
    exp_pre = 32'h77;
`else
    exp_pre = 32'h0;
`endif
    @(negedge clk_i);
    RegWrite_i = 1'b1; RegAddr_i = 5'd10; MemtoReg_i = 1'b1; MemData_i = 32'h77;
    #2 rst_i = 1'b0;
    set_read(5'd10, 5'd10);
    n_checks++;
    if (RSdata_o !== 32'd0 || WBdata_o !== 32'h77) begin
      n_fail++; $display("FAIL in_reset rs=%h wb=%h required 0/77", RSdata_o, WBdata_o);
    end
    @(negedge clk_i);
    rst_i = 1'b1; #1;
    n_checks++;
    if (WrCount_o !== 4'd0 || RTdata_o !== exp_pre) begin
      n_fail++; $display("FAIL discarded cnt=%0d rt=%h required 0/%h", WrCount_o, RTdata_o, exp_pre);
    end
    @(posedge clk_i); #1; RegWrite_i = 1'b0; #1;
    n_checks++;
    if (WrCount_o !== 4'd1 || RSdata_o !== 32'h77) begin
      n_fail++; $display("FAIL first_commit cnt=%0d rs=%h required 1/77", WrCount_o, RSdata_o);
    end
  endtask

  initial begin
    test_reset();
    test_source_select();
    test_x0_write();
    test_bypass();
    test_back_to_back();
    test_wrap();
    test_mid_reset();
    test_reset_discard();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/writeback_regfile.md
WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 Parameter CNT_W, default 32: width of the committed-write counter.
REQ-002 Clocking: one clock; reset is asynchronous and active-low.
REQ-003 clk_i  in  1  pipeline clock; all state updates on the rising edge.
REQ-004 rst_i  in  1  asynchronous, active-low reset.
REQ-005 RegWrite_i  in  1  write-back enable from the MEM/WB stage register.
REQ-006 MemtoReg_i  in  1  write-back source select: 1 = memory data, 0 = ALU data.
REQ-007 MemData_i  in  32  load data from the MEM/WB stage register.
REQ-008 RegData_i  in  32  ALU result from the MEM/WB stage register.
REQ-009 RegAddr_i  in  5  destination register index.
REQ-010 RSaddr_i  in  5  read port A index, driven by ID.
REQ-011 RTaddr_i  in  5  read port B index, driven by ID.
REQ-012 RSdata_o  out  32  read port A data.
REQ-013 RTdata_o  out  32  read port B data.
REQ-014 WBdata_o  out  32  selected write-back value, provided to the forwarding unit.
REQ-015 WrCount_o  out  CNT_W  count of committed register writes.

Function
REQ-016 WBdata_o SHALL be combinational: MemData_i when MemtoReg_i=1, otherwise RegData_i; it is valid regardless of RegWrite_i.
REQ-017 Storage SHALL be 31 x 32-bit registers for x1..x31; x0 has no storage.
REQ-018 A write is committed at a rising edge when rst_i=1, RegWrite_i=1 and RegAddr_i!=0; it stores WBdata_o into x[RegAddr_i].
REQ-019 RegWrite_i=1 with RegAddr_i=0 SHALL leave all state unchanged, including WrCount_o.
REQ-020 Read ports SHALL be combinational, with zero-cycle latency from address to data.
REQ-021 A read of index 0 SHALL return 0 on either port, in every cycle and every configuration.
REQ-022 Both read ports MAY address the same register and SHALL return identical data.
REQ-023 WrCount_o SHALL increment by 1 on each committed write.
REQ-024 WrCount_o SHALL wrap from 2^CNT_W-1 to 0 without flagging.
REQ-025 Back-to-back writes to the same index on consecutive edges SHALL each commit; the last write wins.
REQ-026 Write data SHALL be stored exactly as presented, with no sign or width manipulation.

Reset
REQ-027 rst_i=0 SHALL immediately clear x1..x31 and WrCount_o to 0, without waiting for a clock edge.
REQ-028 While rst_i=0, no write SHALL commit and the read ports SHALL return 0 for all indices.
REQ-029 A reset asserted between edges SHALL discard any pending write; after deassertion, the first write commits at the first rising edge where rst_i=1.
REQ-030 WBdata_o is combinational and SHALL be unaffected by reset.

Configuration
REQ-031 Macro WRITEBACK_BYPASS_EN SHALL select internal write-to-read bypass.
REQ-032 With WRITEBACK_BYPASS_EN defined: when RegWrite_i=1, RegAddr_i!=0, rst_i=1 and a read index equals RegAddr_i, that port SHALL return WBdata_o in the same cycle.
REQ-033 Without WRITEBACK_BYPASS_EN: a read port SHALL return the stored value, and new data SHALL be visible only after the committing edge.
REQ-034 WrCount_o and all write behaviour SHALL be identical in both configurations.

Verification
REQ-035 Reset: assert rst_i=0 mid-cycle after writing x5=0xDEADBEEF -> RSaddr_i=5 immediately reads 0 and WrCount_o=0.
REQ-036 Source select: RegWrite_i=1, RegAddr_i=7, MemtoReg_i=1, MemData_i=0x12345678, RegData_i=0xFFFFFFFF, then one edge -> x7 reads 0x12345678 and WrCount_o=1.
REQ-037 x0 write: RegWrite_i=1, RegAddr_i=0, RegData_i=0xAAAA5555 -> x0 reads 0 and WrCount_o is unchanged.
REQ-038 Bypass: x9=1 stored; present a write x9=0x55 and RSaddr_i=RTaddr_i=9 before the edge -> both ports read 0x55 with the macro and 1 without it; both read 0x55 after the edge.
REQ-039 Counter wrap: CNT_W=4, 16 committed writes -> WrCount_o returns to 0.
REQ-040 Same-index burst: write x3=1, 2, 3 on consecutive edges -> x3 reads 3 and WrCount_o=3.
